matriz_carregador: RTL
======================

Name: matriz_carregador

Overview:
- Upstream stage of `determinante`: receives a byte stream of signed 8-bit matrix elements (row-major) plus a size code.
- Packs the elements into the 200-bit `matriz` bus and `sinalizador` code that `determinante` consumes.
- Presents the packed matrix with a valid/ready handshake and holds it stable until the consumer takes it.

Parameters:
- LARGURA_ELEM, 8, bits per matrix element (signed, two's complement).
- N_MAX, 5, maximum matrix order; the `matriz` width is N_MAX*N_MAX*LARGURA_ELEM = 200.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inicio  in  1  start-load strobe; sampled only when the FSM can accept it.
- tamanho  in  2  size code, latched with `inicio`: 00=2x2, 01=3x3, 10=4x4, 11=5x5.
- abortar  in  1  synchronous abort; returns the block to idle.
- dado  in  8  element byte (signed).
- dado_valid  in  1  `dado` is valid.
- dado_ready  out  1  block accepts `dado` this cycle.
- matriz  out  200  packed matrix to `determinante`.
- sinalizador  out  2  latched size code to `determinante`.
- saida_valid  out  1  `matriz`/`sinalizador` complete and stable.
- saida_ready  in  1  consumer accepts the matrix.
- erro  out  1  one-cycle pulse when `inicio` is rejected.
- contagem  out  5  elements accepted so far in the current load (debug).

Behaviour:
- Reset (async, rst_n=0): state OCIOSO; matriz=0, sinalizador=00, contagem=0, dado_ready=0, saida_valid=0, erro=0.
- Element total per load: T = (tamanho+2)^2, i.e. 4/9/16/25.
- Packing: element k (k=0..T-1, row-major) occupies bits [(T-k)*8-1 -: 8]; bits above T*8 are 0.
  - Implementation: on each accepted byte, matriz <= {matriz[191:0], dado}, starting from zero.
  - Example: a 2x2 load of 2,3,1,4 yields matriz = 200'h02030104.
- FSM states: OCIOSO, CARREGANDO, PRONTO.
  - OCIOSO: dado_ready=0, saida_valid=0. On inicio=1: latch sinalizador<=tamanho, clear matriz and contagem, go to CARREGANDO. dado_ready is 1 from the next cycle.
  - CARREGANDO: dado_ready=1. On dado_valid&dado_ready, shift in the byte and increment contagem. When the accepted byte is the T-th, go to PRONTO. saida_valid rises the cycle after the last byte is accepted (latency 1). Gaps in dado_valid are allowed, with no timeout.
  - PRONTO: saida_valid=1, dado_ready=0. matriz, sinalizador and contagem (=T) are frozen. On saida_ready=1, go to OCIOSO.
    - If inicio=1 in the same cycle as saida_ready=1, the transfer completes and the new load starts directly: next state is CARREGANDO, with sinalizador/matriz/contagem reinitialised from the new tamanho.
- Rejected start: inicio=1 in CARREGANDO, or in PRONTO without saida_ready.
  - The start is ignored; erro=1 for exactly the following cycle.
  - No change to data, contagem or state.
- abortar=1 (any state) has highest priority:
  - next state OCIOSO; matriz=0, contagem=0, sinalizador=00, saida_valid=0.
  - A byte or start presented in the same cycle is discarded.
- Async reset asserted mid-load behaves like power-up reset; no partial matrix is ever flagged valid.
- matriz only changes on byte accept, start, abort or reset. It never changes while saida_valid=1.
- No arithmetic saturation; bytes are stored verbatim.

Decomposition:
- Shared package `matriz_pkg`:
  - LARGURA_ELEM, N_MAX, LARGURA_MATRIZ=200.
  - Size-code constants TAM_2X2..TAM_5X5.
  - The FSM state enum (OCIOSO/CARREGANDO/PRONTO).
  - Function total_elem(tamanho) returning 4/9/16/25.
- No sub-module is needed; shift register, counter and FSM all live in one module.
- Integration top: matriz_carregador -> determinante, with det registered on saida_valid&saida_ready.

Test Plan:
1. Basic 2x2 load: tamanho=00, then bytes 2,3,1,4 sent back-to-back -> saida_valid=1 one cycle after the 4th accept; matriz=200'h02030104; sinalizador=00; contagem=4; downstream det=5.
2. Negative element with gaps: tamanho=01, bytes 2,-3(8'hFD),1,4,5,6,7,8,9 with dado_valid idle between bytes -> matriz low 72 bits = 02FD01040506070809, upper bits 0; det=-27.
3. Backpressure: after a 5x5 load, hold saida_ready=0 for 6 cycles -> matriz stable, dado_ready=0, saida_valid=1 throughout; on saida_ready=1, state returns to OCIOSO next cycle.
4. Rejected start: inicio=1 at contagem=3 of a 4x4 load -> erro pulses for 1 cycle; contagem stays 3; the load completes normally (16 elements, det=16 for the standard 4x4 test matrix).
5. Abort and reset: abortar=1 at contagem=10 of a 5x5 load -> state OCIOSO, matriz=0, saida_valid never asserted. Separately, rst_n=0 mid-load -> all outputs 0 immediately (async).
6. Back-to-back loads: in PRONTO, assert saida_ready=1 and inicio=1 with tamanho=10 in the same cycle -> next cycle is CARREGANDO, sinalizador=10, matriz=0, contagem=0, erro=0.

Source files
------------

// File: rtl/matriz_pkg.sv
// Shared constants, FSM state type and size-code helper for the matrix loader.
package matriz_pkg;

    localparam int unsigned LARGURA_ELEM   = 8;
    localparam int unsigned N_MAX          = 5;
    localparam int unsigned LARGURA_MATRIZ = N_MAX * N_MAX * LARGURA_ELEM;

    localparam logic [1:0] TAM_2X2 = 2'b00;
    localparam logic [1:0] TAM_3X3 = 2'b01;
    localparam logic [1:0] TAM_4X4 = 2'b10;
    localparam logic [1:0] TAM_5X5 = 2'b11;

    typedef enum logic [1:0] {
        OCIOSO,
        CARREGANDO,
        PRONTO
    } estado_t;

    function automatic logic [4:0] total_elem(input logic [1:0] tamanho);
        logic [4:0] t;
        case (tamanho)
            TAM_2X2: t = 5'd4;
            TAM_3X3: t = 5'd9;
            TAM_4X4: t = 5'd16;
            default: t = 5'd25;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/matriz_carregador.sv
// Packs a row-major byte stream of signed elements into the matrix bus consumed
// by determinante, and holds it behind a valid/ready handshake.
module matriz_carregador
    import matriz_pkg::*;
#(
    parameter int unsigned LARGURA_ELEM = matriz_pkg::LARGURA_ELEM,
    parameter int unsigned N_MAX        = matriz_pkg::N_MAX
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   inicio,
    input  logic [1:0]                             tamanho,
    input  logic                                   abortar,
    input  logic [LARGURA_ELEM-1:0]                dado,
    input  logic                                   dado_valid,
    output logic                                   dado_ready,
    output logic [N_MAX*N_MAX*LARGURA_ELEM-1:0]    matriz,
    output logic [1:0]                             sinalizador,
    output logic                                   saida_valid,
    input  logic                                   saida_ready,
    output logic                                   erro,
    output logic [4:0]                             contagem
);

    localparam int unsigned LM = N_MAX * N_MAX * LARGURA_ELEM;

    estado_t         estado_q, estado_d;
    logic [LM-1:0]   matriz_q, matriz_d;
    logic [1:0]      sinal_q, sinal_d;
    logic [4:0]      cont_q, cont_d;
    logic            erro_q, erro_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= OCIOSO;
            matriz_q <= '0;
            sinal_q  <= '0;
            cont_q   <= '0;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            matriz_q <= matriz_d;
            sinal_q  <= sinal_d;
            cont_q   <= cont_d;
            erro_q   <= erro_d;
        end
    end

    // Abort dominates; a start is only honoured in OCIOSO or when PRONTO hands off.
    always_comb begin
        estado_d = estado_q;
        matriz_d = matriz_q;
        sinal_d  = sinal_q;
        cont_d   = cont_q;
        erro_d   = 1'b0;
        if (abortar) begin
            estado_d = OCIOSO;
            matriz_d = '0;
            sinal_d  = '0;
            cont_d   = '0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (inicio) begin
                        estado_d = CARREGANDO;
                        sinal_d  = tamanho;
                        matriz_d = '0;
                        cont_d   = '0;
                    end
                end
                CARREGANDO: begin
                    if (inicio) erro_d = 1'b1;
                    if (dado_valid) begin
                        matriz_d = {matriz_q[LM-LARGURA_ELEM-1:0], dado};
                        cont_d   = cont_q + 5'd1;
                        if (cont_q == total_elem(sinal_q) - 5'd1) estado_d = PRONTO;
                    end
                end
                PRONTO: begin
                    if (saida_ready) begin
                        if (inicio) begin
                            estado_d = CARREGANDO;
                            sinal_d  = tamanho;
                            matriz_d = '0;
                            cont_d   = '0;
                        end else begin
                            estado_d = OCIOSO;
                        end
                    end else if (inicio) begin
                        erro_d = 1'b1;
                    end
                end
                default: estado_d = OCIOSO;
            endcase
        end
    end

    always_comb begin
        dado_ready  = (estado_q == CARREGANDO);
        saida_valid = (estado_q == PRONTO);
    end

    assign matriz      = matriz_q;
    assign sinalizador = sinal_q;
    assign contagem    = cont_q;
    assign erro        = erro_q;

endmodule
